// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the per-axis phase encoding.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_CNT_W     = 10;

    function automatic int total_len(input int vis, input int fr, input int sy, input int bk);
        return vis + fr + sy + bk;
    endfunction

    localparam int H_TOTAL = total_len(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int V_TOTAL = total_len(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        FRONT   = 2'd1,
        SYNC    = 2'd2,
        BACK    = 2'd3
    } phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with its visible/front/sync/back phase FSM.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             adv_i,
    input  logic [CNT_W-1:0] len_visible_i,
    input  logic [CNT_W-1:0] len_front_i,
    input  logic [CNT_W-1:0] len_sync_i,
    input  logic [CNT_W-1:0] len_back_i,
    output logic [CNT_W-1:0] cnt_o,
    output phase_t           phase_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] cnt_q;
    phase_t           phase_q;
    logic [CNT_W-1:0] end_visible;
    logic [CNT_W-1:0] end_front;
    logic [CNT_W-1:0] end_sync;
    logic [CNT_W-1:0] end_last;
    logic             at_last;

    // Last count value of each segment; a phase is left when its last count advances.
    assign end_visible = len_visible_i - CNT_W'(1);
    assign end_front   = len_visible_i + len_front_i - CNT_W'(1);
    assign end_sync    = len_visible_i + len_front_i + len_sync_i - CNT_W'(1);
    assign end_last    = len_visible_i + len_front_i + len_sync_i + len_back_i - CNT_W'(1);
    assign at_last     = (cnt_q == end_last);

    // Counter and phase advance together so the phase always describes cnt_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= {CNT_W{1'b0}};
            phase_q <= VISIBLE;
        end else if (adv_i) begin
            if (at_last) begin
                cnt_q   <= {CNT_W{1'b0}};
                phase_q <= VISIBLE;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                case (phase_q)
                    VISIBLE: if (cnt_q == end_visible) phase_q <= FRONT;
                    FRONT:   if (cnt_q == end_front)   phase_q <= SYNC;
                    SYNC:    if (cnt_q == end_sync)    phase_q <= BACK;
                    BACK:    phase_q <= BACK;
                    default: phase_q <= VISIBLE;
                endcase
            end
        end
    end

    assign cnt_o   = cnt_q;
    assign phase_o = phase_q;
    assign wrap_o  = adv_i & at_last;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered sync, video-active and pixel coordinates.
// Optional frame_start pulse port is built only when VGA_TIMING_FRAME_PULSE_EN is defined.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y
`ifdef VGA_TIMING_FRAME_PULSE_EN
    ,
    output logic             frame_start
`endif
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    phase_t           h_phase;
    phase_t           v_phase;
    logic             h_wrap;
    logic             v_wrap;
    logic             v_adv;

    logic [CNT_W-1:0] pixel_x_q;
    logic [CNT_W-1:0] pixel_y_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             video_on_q;

    assign v_adv = pix_en & h_wrap;

    vga_axis_counter #(.CNT_W(CNT_W)) u_h_axis (
        .clk_i         (clk_in),
        .rst_ni        (reset_n),
        .adv_i         (pix_en),
        .len_visible_i (CNT_W'(H_VISIBLE)),
        .len_front_i   (CNT_W'(H_FRONT)),
        .len_sync_i    (CNT_W'(H_SYNC)),
        .len_back_i    (CNT_W'(H_BACK)),
        .cnt_o         (h_cnt),
        .phase_o       (h_phase),
        .wrap_o        (h_wrap)
    );

    vga_axis_counter #(.CNT_W(CNT_W)) u_v_axis (
        .clk_i         (clk_in),
        .rst_ni        (reset_n),
        .adv_i         (v_adv),
        .len_visible_i (CNT_W'(V_VISIBLE)),
        .len_front_i   (CNT_W'(V_FRONT)),
        .len_sync_i    (CNT_W'(V_SYNC)),
        .len_back_i    (CNT_W'(V_BACK)),
        .cnt_o         (v_cnt),
        .phase_o       (v_phase),
        .wrap_o        (v_wrap)
    );

    // The frame-end carry has no consumer at this level.
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

    // Outputs sample the pre-increment position so all of them change on one edge.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x_q  <= {CNT_W{1'b0}};
            pixel_y_q  <= {CNT_W{1'b0}};
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
        end else if (pix_en) begin
            pixel_x_q  <= h_cnt;
            pixel_y_q  <= v_cnt;
            hsync_q    <= (h_phase != SYNC);
            vsync_q    <= (v_phase != SYNC);
            video_on_q <= (h_phase == VISIBLE) && (v_phase == VISIBLE);
        end
    end

    assign pixel_x  = pixel_x_q;
    assign pixel_y  = pixel_y_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = video_on_q;

`ifdef VGA_TIMING_FRAME_PULSE_EN
    logic frame_start_q;

    // High for the single cycle following the edge that presents the origin.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_en && (h_cnt == {CNT_W{1'b0}}) && (v_cnt == {CNT_W{1'b0}});
        end
    end

    assign frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny-raster instance for frame checks.
module tb_vga_timing_gen;

    logic       clk_in = 1'b0;
    logic       reset_n;
    logic       pix_en;
    logic       hs_d, vs_d, vo_d, hs_s, vs_s, vo_s;
    logic [9:0] x_d, y_d, x_s, y_s;
`ifdef VGA_TIMING_FRAME_PULSE_EN
    logic       fs_d, fs_s;
`endif

    always #5 clk_in = ~clk_in;

    vga_timing_gen dut (
        .clk_in(clk_in), .reset_n(reset_n), .pix_en(pix_en),
        .hsync(hs_d), .vsync(vs_d), .video_on(vo_d), .pixel_x(x_d), .pixel_y(y_d)
`ifdef VGA_TIMING_FRAME_PULSE_EN
        , .frame_start(fs_d)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CNT_W(10)
    ) dut_s (
        .clk_in(clk_in), .reset_n(reset_n), .pix_en(pix_en),
        .hsync(hs_s), .vsync(vs_s), .video_on(vo_s), .pixel_x(x_s), .pixel_y(y_s)
`ifdef VGA_TIMING_FRAME_PULSE_EN
        , .frame_start(fs_s)
`endif
    );

    typedef struct { int hv, hf, hsy, hb, vv, vf, vsy, vb; } cfg_t;
    typedef struct { int x, y, hs, vs, vo; } exp_t;
    typedef struct { int n; int x, y, hs, vs, vo; } vec_t;

    cfg_t cfg_d, cfg_s;
    vec_t tbl[12];
    int   n, cyc, passed, total;
    int   c0, c1, sf0, sf1;
    bit   regular;

    // Position presented after k pix_en edges since reset, from the raster rules.
    function automatic exp_t model(cfg_t c, int k);
        exp_t e;
        int ht, vt, p;
        ht = c.hv + c.hf + c.hsy + c.hb;
        vt = c.vv + c.vf + c.vsy + c.vb;
        if (k == 0) begin
            e.x = 0; e.y = 0; e.hs = 1; e.vs = 1; e.vo = 0;
        end else begin
            p    = (k - 1) % (ht * vt);
            e.x  = p % ht;
            e.y  = p / ht;
            e.hs = (e.x >= c.hv + c.hf && e.x < c.hv + c.hf + c.hsy) ? 0 : 1;
            e.vs = (e.y >= c.vv + c.vf && e.y < c.vv + c.vf + c.vsy) ? 0 : 1;
            e.vo = (e.x < c.hv && e.y < c.vv) ? 1 : 0;
        end
        return e;
    endfunction

    function automatic int frame_len(cfg_t c);
        return (c.hv + c.hf + c.hsy + c.hb) * (c.vv + c.vf + c.vsy + c.vb);
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s at n=%0d cyc=%0d: got %0d expected %0d", name, n, cyc, act, exp);
    endtask

    task automatic check_all(bit edge_adv);
        exp_t e;
        e = model(cfg_d, n);
        chk("def.x", int'(x_d), e.x);   chk("def.y", int'(y_d), e.y);
        chk("def.hs", int'(hs_d), e.hs); chk("def.vs", int'(vs_d), e.vs);
        chk("def.vo", int'(vo_d), e.vo);
        e = model(cfg_s, n);
        chk("sml.x", int'(x_s), e.x);   chk("sml.y", int'(y_s), e.y);
        chk("sml.hs", int'(hs_s), e.hs); chk("sml.vs", int'(vs_s), e.vs);
        chk("sml.vo", int'(vo_s), e.vo);
`ifdef VGA_TIMING_FRAME_PULSE_EN
        chk("def.fs", int'(fs_d), (edge_adv && ((n - 1) % frame_len(cfg_d) == 0)) ? 1 : 0);
        chk("sml.fs", int'(fs_s), (edge_adv && ((n - 1) % frame_len(cfg_s) == 0)) ? 1 : 0);
`else
        if (edge_adv && n < 0) $display("n negative");
`endif
    endtask

    task automatic tick(bit en);
        bit adv;
        pix_en = en;
        @(posedge clk_in);
        #1;
        cyc++;
        adv = en && reset_n;
        if (adv) n++;
        if (adv && regular) begin
            if (x_d == 10'd0 && y_d == 10'd0 && c0 < 0) c0 = cyc;
            if (x_d == 10'd0 && y_d == 10'd1 && c1 < 0) c1 = cyc;
            if (x_s == 10'd0 && y_s == 10'd0) begin
                if (sf0 < 0) sf0 = cyc;
                else if (sf1 < 0) sf1 = cyc;
            end
        end
        check_all(adv);
    endtask

    initial begin
        cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33};
        cfg_s = '{8, 2, 3, 2, 6, 2, 2, 3};
        tbl[0]  = '{1,    0,   0, 1, 1, 1};
        tbl[1]  = '{2,    1,   0, 1, 1, 1};
        tbl[2]  = '{640,  639, 0, 1, 1, 1};
        tbl[3]  = '{641,  640, 0, 1, 1, 0};
        tbl[4]  = '{656,  655, 0, 1, 1, 0};
        tbl[5]  = '{657,  656, 0, 0, 1, 0};
        tbl[6]  = '{752,  751, 0, 0, 1, 0};
        tbl[7]  = '{753,  752, 0, 1, 1, 0};
        tbl[8]  = '{800,  799, 0, 1, 1, 0};
        tbl[9]  = '{801,  0,   1, 1, 1, 1};
        tbl[10] = '{1600, 799, 1, 1, 1, 0};
        tbl[11] = '{1601, 0,   2, 1, 1, 1};
        n = 0; cyc = 0; passed = 0; total = 0;
        c0 = -1; c1 = -1; sf0 = -1; sf1 = -1; regular = 1'b0;
        reset_n = 1'b0;
        pix_en  = 1'b0;

        // Held in reset, then released with pix_en idle: raster must not move.
        for (int i = 0; i < 5; i++) tick(1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) tick(1'b0);

        // Regular every-other-cycle pix_en walking the table past two line wraps.
        regular = 1'b1;
        for (int i = 0; i < 12; i++) begin
            while (n < tbl[i].n) begin
                tick(1'b1);
                tick(1'b0);
            end
            chk("tbl.x", int'(x_d), tbl[i].x);
            chk("tbl.y", int'(y_d), tbl[i].y);
            chk("tbl.hs", int'(hs_d), tbl[i].hs);
            chk("tbl.vs", int'(vs_d), tbl[i].vs);
            chk("tbl.vo", int'(vo_d), tbl[i].vo);
        end
        regular = 1'b0;
        chk("line_period_cycles", c1 - c0, 1600);
        chk("small_frame_period_cycles", sf1 - sf0, 390);

        // Irregular pix_en at roughly 30% duty.
        for (int i = 0; i < 3000; i++) tick($urandom_range(0, 99) < 30);

        // Walk to column 300, then drop reset between clock edges.
        for (int i = 0; i < 2000 && ((n - 1) % 800) != 300; i++) begin
            tick(1'b1);
            tick(1'b0);
        end
        chk("reached_x300", int'(x_d), 300);
        #2;
        reset_n = 1'b0;
        #1;
        n = 0;
        check_all(1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1);
        reset_n = 1'b1;
        tick(1'b0);
        tick(1'b1);
        chk("post_reset_x", int'(x_d), 0);
        chk("post_reset_vo", int'(vo_d), 1);
        for (int i = 0; i < 400; i++) tick(1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
